// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between two requesters, one operation in
// flight, with a watchdog that aborts an operation whose done never arrives.
module fpu_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       opcode0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  output logic             rsp_valid0,
  input  logic             req1,
  input  logic [1:0]       opcode1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic [1:0]       fpu_opcode,
  output logic             fpu_start,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] fpu_a_q, fpu_a_d;
  logic [WIDTH-1:0] fpu_b_q, fpu_b_d;
  logic [1:0]       fpu_op_q, fpu_op_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             win0, win1;

  // A tie goes to whoever was not served last; reset gates the grant so
  // every output reads 0 while reset is held.
  assign win0 = reset & req0 & (~req1 | last_q);
  assign win1 = reset & req1 & (~req0 | ~last_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      fpu_a_q    <= fpu_a_d;
      fpu_b_q    <= fpu_b_d;
      fpu_op_q   <= fpu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    fpu_a_d    = fpu_a_q;
    fpu_b_d    = fpu_b_q;
    fpu_op_d   = fpu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    fpu_start  = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win0) begin
          gnt0     = 1'b1;
          owner_d  = 1'b0;
          fpu_a_d  = a0;
          fpu_b_d  = b0;
          fpu_op_d = opcode0;
          state_d  = S_ISSUE;
        end else if (win1) begin
          gnt1     = 1'b1;
          owner_d  = 1'b1;
          fpu_a_d  = a1;
          fpu_b_d  = b1;
          fpu_op_d = opcode1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fpu_start = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (fpu_done) begin
          rsp_data_d = fpu_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid0 = ~owner_q;
        rsp_valid1 = owner_q;
        last_d     = owner_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_opcode = fpu_op_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: the driver queues expected grants and
// responses, a negedge monitor pops and compares, and a small FPU model answers.
`timescale 1ns/1ps
module tb_fpu_arbiter;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [1:0]       opcode0, opcode1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, rsp_valid0, rsp_valid1;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic [WIDTH-1:0] fpu_a, fpu_b;
  logic [1:0]       fpu_opcode;
  logic             fpu_start;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_done;
  logic             busy;

  fpu_arbiter #(.WIDTH(32), .TIMEOUT(64), .CW(7)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .opcode0(opcode0), .a0(a0), .b0(b0), .gnt0(gnt0), .rsp_valid0(rsp_valid0),
    .req1(req1), .opcode1(opcode1), .a1(a1), .b1(b1), .gnt1(gnt1), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_start(fpu_start),
    .fpu_result(fpu_result), .fpu_done(fpu_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          dly;   // start-to-done cycles, 0 = FPU never answers
    logic [31:0] res;   // expected rsp_data
    logic        err;
    bit          rsp;   // a response is expected for this grant
    int          gap;   // cycles from previous rsp_valid to this gnt, -1 = unchecked
    int          lat;   // cycles from fpu_start to rsp_valid
  } exp_t;

  exp_t gexp[$];
  exp_t cur;
  bit   have_cur = 0;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, gcyc = 0, scyc = 0, rsp_cyc = 0;
  int rsp_count = 0;
  int dcnt = 0;
  logic [31:0] cur_res = '0;
  bit   spur_arm = 0, spur_pending = 0;
  int   hold0 = 0, hold1 = 0;

  localparam logic [31:0] F25  = 32'h41C80000;
  localparam logic [31:0] F5   = 32'h40A00000;
  localparam logic [31:0] F30  = 32'h41F00000;
  localparam logic [31:0] F20  = 32'h41A00000;
  localparam logic [31:0] F125 = 32'h42FA0000;
  localparam logic [31:0] F1   = 32'h3F800000;
  localparam logic [31:0] F2   = 32'h40000000;
  localparam logic [31:0] F3   = 32'h40400000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int owner, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int dly, input logic [31:0] res,
                               input logic err, input bit rsp, input int gap, input int lat);
    exp_t e;
    e.owner = owner; e.op = op; e.a = a; e.b = b; e.dly = dly; e.res = res;
    e.err = err; e.rsp = rsp; e.gap = gap; e.lat = lat;
    gexp.push_back(e);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FPU model: optional spurious done in the ISSUE cycle, real done dly cycles after start.
  initial begin
    fpu_done   = 1'b0;
    fpu_result = '0;
    forever begin
      @(posedge clk); #1;
      fpu_done = 1'b0;
      if (spur_pending) begin
        spur_pending = 0;
        fpu_done     = 1'b1;
        fpu_result   = 32'hDEADBEEF;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          fpu_done   = 1'b1;
          fpu_result = cur_res;
        end
      end
    end
  end

  // Monitor: compares every grant, start and response against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        have_cur = 0;
      end else begin
        if (gnt0 || gnt1) begin
          check("gnt_exclusive", {gnt0, gnt1} == 2'b11, 0);
          check("gnt_expected", gexp.size() > 0, 1);
          if (gexp.size() > 0) begin
            cur = gexp.pop_front();
            check("gnt_owner", gnt1, cur.owner);
            check("busy_at_gnt", busy, 0);
            if (cur.gap >= 0) check("gnt_gap", cyc - rsp_cyc, cur.gap);
            gcyc     = cyc;
            have_cur = 1;
            if (spur_arm) begin
              spur_arm     = 0;
              spur_pending = 1;
            end
          end
        end
        if (fpu_start && have_cur) begin
          check("start_latency", cyc - gcyc, 1);
          check("fpu_a", fpu_a, cur.a);
          check("fpu_b", fpu_b, cur.b);
          check("fpu_opcode", fpu_opcode, cur.op);
          scyc    = cyc;
          dcnt    = cur.dly;
          cur_res = cur.res;
        end
        if (rsp_valid0 || rsp_valid1) begin
          rsp_count++;
          rsp_cyc = cyc;
          check("rsp_exclusive", {rsp_valid0, rsp_valid1} == 2'b11, 0);
          check("rsp_expected", have_cur && cur.rsp, 1);
          if (have_cur && cur.rsp) begin
            check("rsp_owner", rsp_valid1, cur.owner);
            check("rsp_data", rsp_data, cur.res);
            check("rsp_err", rsp_err, cur.err);
            check("rsp_latency", cyc - scyc, cur.lat);
            check("busy_at_rsp", busy, 1);
          end
          have_cur = 0;
        end
      end
    end
  end

  // One cycle; a granted requester drops req unless it still holds further requests.
  task automatic step();
    logic g0, g1;
    @(negedge clk);
    g0 = gnt0;
    g1 = gnt1;
    @(posedge clk); #1;
    if (g0) begin if (hold0 > 0) hold0--; else req0 = 1'b0; end
    if (g1) begin if (hold1 > 0) hold1--; else req1 = 1'b0; end
  endtask

  task automatic wait_rsp(input string name, input int target, input int budget);
    int n = 0;
    while (rsp_count < target && n < budget) begin
      step();
      n++;
    end
    check(name, rsp_count >= target, 1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, fpu_start, busy, fpu_opcode}, '0);
    check({name, "_data"}, {fpu_a, fpu_b}, '0);
    check({name, "_rsp"}, rsp_data, '0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; opcode0 = '0; opcode1 = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    req0 = 1'b1; #1;
    check("gnt_in_reset", {gnt0, gnt1}, 0);
    req0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single add from requester 0.
    push(0, 2'b00, F25, F5, 2, F30, 0, 1, -1, 3);
    req0 = 1'b1; opcode0 = 2'b00; a0 = F25; b0 = F5;
    wait_rsp("wait_add", 1, 20);

    // Tie straight out of reset: requester 0 first, requester 1 one cycle after rsp.
    pulse_reset();
    base = rsp_count;
    push(0, 2'b01, F25, F5, 2, F20, 0, 1, -1, 3);
    push(1, 2'b10, F25, F5, 2, F125, 0, 1, 1, 3);
    req0 = 1'b1; opcode0 = 2'b01; a0 = F25; b0 = F5;
    req1 = 1'b1; opcode1 = 2'b10; a1 = F25; b1 = F5;
    wait_rsp("wait_tie", base + 2, 30);

    // Both held for four operations: grants alternate 0,1,0,1.
    base = rsp_count;
    push(0, 2'b01, F25, F5, 2, F20, 0, 1, -1, 3);
    push(1, 2'b10, F25, F5, 3, F125, 0, 1, 1, 4);
    push(0, 2'b01, F25, F5, 4, F20, 0, 1, 1, 5);
    push(1, 2'b10, F25, F5, 2, F125, 0, 1, 1, 3);
    hold0 = 1; hold1 = 1;
    req0 = 1'b1; req1 = 1'b1;
    wait_rsp("wait_alternate", base + 4, 60);

    // Hung FPU: watchdog abort, then a normal operation.
    base = rsp_count;
    push(0, 2'b00, F25, F5, 0, 32'h0, 1, 1, -1, 65);
    req0 = 1'b1; opcode0 = 2'b00;
    wait_rsp("wait_timeout", base + 1, 100);
    push(1, 2'b00, F1, F2, 3, F3, 0, 1, -1, 4);
    req1 = 1'b1; opcode1 = 2'b00; a1 = F1; b1 = F2;
    wait_rsp("wait_after_timeout", base + 2, 20);

    // Reset during WAIT; the late done must not produce a response.
    base = rsp_count;
    push(1, 2'b10, F25, F5, 5, F125, 0, 0, -1, 0);
    req1 = 1'b1; opcode1 = 2'b10; a1 = F25; b1 = F5;
    repeat (4) step();
    check("busy_before_abort", busy, 1);
    reset = 1'b0; #1;
    check_all_zero("reset_in_wait");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) step();
    check("no_rsp_after_abort", rsp_count, base);
    check("idle_after_abort", busy, 0);
    push(0, 2'b00, F25, F5, 2, F30, 0, 1, -1, 3);
    push(1, 2'b11, F25, F5, 2, F5, 0, 1, 1, 3);
    req0 = 1'b1; opcode0 = 2'b00; a0 = F25; b0 = F5;
    req1 = 1'b1; opcode1 = 2'b11; a1 = F25; b1 = F5;
    wait_rsp("wait_tie_after_abort", base + 2, 30);

    // Divide from requester 1 with a spurious done in the ISSUE cycle.
    base = rsp_count;
    spur_arm = 1;
    push(1, 2'b11, F25, F5, 3, F5, 0, 1, -1, 4);
    req1 = 1'b1; opcode1 = 2'b11; a1 = F25; b1 = F5;
    wait_rsp("wait_spurious", base + 1, 20);
    repeat (3) step();

    check("all_grants_seen", gexp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks, expected completion", n_chk);
    $fatal(1, "global timeout");
  end

endmodule
